// File: rtl/paddle_adc_pkg.sv
// -----------------------------------------------------------------------------
// paddle_adc_pkg
// Shared definitions for the paddle ADC conditioning block:
//   - state_t      : sequencing FSM states
//   - DEF_ADC_MIN  : default lower clamp bound (raw 12-bit counts)
//   - DEF_ADC_MAX  : default upper clamp bound (raw 12-bit counts)
//   - SCALE        : output full-scale multiplier (255)
//   - paddle_t     : signed 8-bit paddle position
// -----------------------------------------------------------------------------
package paddle_adc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLAMP,
      S_MUL,
      S_DIV,
      S_FILT,
      S_DONE
   } state_t;

   localparam int DEF_ADC_MIN = 300;
   localparam int DEF_ADC_MAX = 1500;

   // The multiply by SCALE is realised as (d << 8) - d in the datapath.
   localparam int SCALE = 255;

   typedef logic signed [7:0] paddle_t;

endpackage

// File: rtl/paddle_adc_cond_div8.sv
// -----------------------------------------------------------------------------
// paddle_div8
// Eight-iteration restoring divider producing an 8-bit quotient. The caller
// guarantees dividend < divisor * 256, so the first trial subtraction uses
// divisor << 7 and eight steps resolve the full quotient.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-high reset
//   start     in   load dividend/divisor and begin iterating
//   dividend  in   19-bit unsigned dividend
//   divisor   in   11-bit unsigned divisor (non-zero)
//   done      out  high during the eighth iteration cycle
//   quotient  out  8-bit quotient, valid while done is high
// -----------------------------------------------------------------------------
module paddle_div8 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [18:0] dividend,
   input  logic [10:0] divisor,
   output logic        done,
   output logic [7:0]  quotient
);

   logic [18:0] rem;
   logic [17:0] dsh;
   logic [6:0]  quo;
   logic [2:0]  cnt;
   logic        run;
   logic        fits;

   assign fits = (rem >= {1'b0, dsh});

   // The last quotient bit is taken straight from the comparator so the
   // caller sees the complete result in the eighth cycle, not the ninth.
   assign done     = run && (cnt == 3'd7);
   assign quotient = {quo, fits};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem <= '0;
         dsh <= '0;
         quo <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         rem <= dividend;
         dsh <= {divisor, 7'd0};
         quo <= '0;
         cnt <= '0;
         run <= 1'b1;
      end else if (run) begin
         if (fits) begin
            rem <= rem - {1'b0, dsh};
         end
         quo <= {quo[5:0], fits};
         dsh <= dsh >> 1;
         cnt <= cnt + 3'd1;
         if (cnt == 3'd7) begin
            run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/paddle_adc_cond.sv
// -----------------------------------------------------------------------------
// paddle_adc_cond
// Turns raw LTC2308 conversions (two 12-bit channels) into signed 8-bit paddle
// positions: synchronise the ADC new-sample toggle, clamp each channel to a
// calibrated window, rescale to 0..255 with a sequential divider, optionally
// smooth with a moving average, then convert offset-binary to signed.
//
// Optional feature: define PADDLE_AVG_EN to enable the per-channel moving
// average of 2**AVG_LOG2 samples. Without it the filter stage passes the
// quotient straight through (same latency).
//
// Ports:
//   clk_sys   in   system clock (all logic and outputs)
//   reset     in   asynchronous active-high reset
//   adc_sync  in   new-sample toggle from the ADC clock domain
//   adc_dout  in   {ch1[23:12], ch0[11:0]}, stable between toggles
//   paddle_x  out  signed position from ch0
//   paddle_y  out  signed position from ch1
//   valid     out  one-cycle pulse when paddle_x/paddle_y update
//   busy      out  high while a sample is being processed
// -----------------------------------------------------------------------------
module paddle_adc_cond
   import paddle_adc_pkg::*;
#(
   parameter int ADC_MIN  = DEF_ADC_MIN,
   parameter int ADC_MAX  = DEF_ADC_MAX,
   parameter int AVG_LOG2 = 2
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        adc_sync,
   input  logic [23:0] adc_dout,
   output paddle_t     paddle_x,
   output paddle_t     paddle_y,
   output logic        valid,
   output logic        busy
);

   localparam logic [11:0] MIN12 = 12'(ADC_MIN);
   localparam logic [11:0] MAX12 = 12'(ADC_MAX);
   localparam logic [10:0] SPAN  = 11'(ADC_MAX - ADC_MIN);

   // ---------------- toggle synchroniser and change detect ----------------
   logic sync1, sync2, sync3;
   logic capture;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= adc_sync;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign capture = sync2 ^ sync3;

   // ---------------- datapath signals ----------------
   state_t      state;
   logic        ch;
   logic [23:0] pend_data;
   logic        pend_full;
   logic [23:0] work;
   logic [11:0] c_reg;
   logic [7:0]  q_reg;
   logic [7:0]  f0;
   logic [7:0]  f1;

   logic        take;
   logic [11:0] raw;
   logic [11:0] clamped;
   logic [18:0] d19;
   logic [18:0] n19;
   logic        div_start;
   logic        div_done;
   logic [7:0]  div_q;
   logic [7:0]  f_new;

   // The pending sample is consumed whenever the FSM is able to start work.
   assign take    = pend_full && ((state == S_IDLE) || (state == S_DONE));
   assign raw     = ch ? work[23:12] : work[11:0];
   assign clamped = (raw < MIN12) ? MIN12 : ((raw > MAX12) ? MAX12 : raw);

   // n = d * 255 without a multiplier; d <= 1200 keeps n inside 19 bits.
   assign d19       = 19'(c_reg - MIN12);
   assign n19       = (d19 << 8) - d19;
   assign div_start = (state == S_MUL);

   paddle_div8 u_div (
      .clk      (clk_sys),
      .reset    (reset),
      .start    (div_start),
      .dividend (n19),
      .divisor  (SPAN),
      .done     (div_done),
      .quotient (div_q)
   );

   // ---------------- filter stage ----------------
`ifdef PADDLE_AVG_EN
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int AW    = 8 + AVG_LOG2;

   logic [AW-1:0] acc_next [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [7:0]          hist [DEPTH];
      logic [AW-1:0]       acc;
      logic [AVG_LOG2-1:0] wptr;

      // Running sum: add the newest quotient, drop the oldest history entry.
      assign acc_next[gi] = acc + AW'(q_reg) - AW'(hist[wptr]);

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
               hist[j] <= 8'd128;
            end
            acc  <= AW'(128 << AVG_LOG2);
            wptr <= '0;
         end else if ((state == S_FILT) && (ch == 1'(gi))) begin
            hist[wptr] <= q_reg;
            acc        <= acc_next[gi];
            wptr       <= wptr + 1'b1;
         end
      end
   end

   assign f_new = ch ? acc_next[1][AW-1:AVG_LOG2] : acc_next[0][AW-1:AVG_LOG2];
`else
   assign f_new = q_reg;
`endif

   // ---------------- sequencing FSM ----------------
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         ch        <= 1'b0;
         pend_data <= '0;
         pend_full <= 1'b0;
         work      <= '0;
         c_reg     <= '0;
         q_reg     <= '0;
         f0        <= '0;
         f1        <= '0;
         paddle_x  <= '0;
         paddle_y  <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid <= 1'b0;

         // Latest toggle wins; a capture in the same cycle as a take refills.
         if (capture) begin
            pend_data <= adc_dout;
         end
         pend_full <= capture | (pend_full & ~take);

         unique case (state)
            S_IDLE: begin
               if (pend_full) begin
                  work  <= pend_data;
                  ch    <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_CLAMP;
               end
            end
            S_CLAMP: begin
               c_reg <= clamped;
               state <= S_MUL;
            end
            S_MUL: begin
               state <= S_DIV;
            end
            S_DIV: begin
               if (div_done) begin
                  q_reg <= div_q;
                  state <= S_FILT;
               end
            end
            S_FILT: begin
               if (ch) begin
                  f1    <= f_new;
                  state <= S_DONE;
               end else begin
                  f0    <= f_new;
                  ch    <= 1'b1;
                  state <= S_CLAMP;
               end
            end
            S_DONE: begin
               paddle_x <= f0 ^ 8'h80;
               paddle_y <= f1 ^ 8'h80;
               valid    <= 1'b1;
               if (pend_full) begin
                  work  <= pend_data;
                  ch    <= 1'b0;
                  state <= S_CLAMP;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_paddle_adc_cond.sv
// -----------------------------------------------------------------------------
// tb_paddle_adc_cond
// Scoreboard bench for paddle_adc_cond. Stimulus pushes the expected
// {paddle_x, paddle_y, arrival cycle} computed from plain arithmetic; an
// independent monitor pops an entry for every valid pulse and compares.
// -----------------------------------------------------------------------------
module tb_paddle_adc_cond;
   import paddle_adc_pkg::*;

   localparam int MINV = 300;
   localparam int MAXV = 1500;
   localparam int LOG2 = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        adc_sync = 1'b0;
   logic [23:0] adc_dout = '0;
   paddle_t     paddle_x;
   paddle_t     paddle_y;
   logic        valid;
   logic        busy;
   logic [7:0]  ux;
   logic [7:0]  uy;

   assign ux = paddle_x;
   assign uy = paddle_y;

   paddle_adc_cond #(.ADC_MIN(MINV), .ADC_MAX(MAXV), .AVG_LOG2(LOG2)) dut (
      .clk_sys  (clk),
      .reset    (reset),
      .adc_sync (adc_sync),
      .adc_dout (adc_dout),
      .paddle_x (paddle_x),
      .paddle_y (paddle_y),
      .valid    (valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int x;
      int y;
      int due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_valid = 0;
   int   last_due = 0;
   int   hist0[$];
   int   hist1[$];

   // ---------------- reference model ----------------
   function automatic int scale(input int rawv);
      int c;
      c = (rawv < MINV) ? MINV : ((rawv > MAXV) ? MAXV : rawv);
      return ((c - MINV) * 255) / (MAXV - MINV);
   endfunction

   task automatic model_reset();
      hist0.delete();
      hist1.delete();
      for (int i = 0; i < (1 << LOG2); i++) begin
         hist0.push_back(128);
         hist1.push_back(128);
      end
   endtask

   task automatic filt(input int q, input int chn, output int f);
`ifdef PADDLE_AVG_EN
      int sum;
      sum = 0;
      if (chn == 0) begin
         hist0.push_back(q);
         void'(hist0.pop_front());
         foreach (hist0[i]) sum += hist0[i];
      end else begin
         hist1.push_back(q);
         void'(hist1.pop_front());
         foreach (hist1[i]) sum += hist1[i];
      end
      f = sum / (1 << LOG2);
`else
      f = q + 0 * chn;
`endif
   endtask

   // Issue one toggle. When track is set, the sample is expected to surface:
   // work starts 4 edges after the toggle edge count (or straight after the
   // previous result) and the result appears 23 cycles after work starts.
   task automatic send(input int c0, input int c1, input bit track);
      int   t, st, f0, f1;
      exp_t e;
      @(negedge clk);
      adc_dout = {12'(c1), 12'(c0)};
      adc_sync = ~adc_sync;
      t = cyc;
      if (track) begin
         st = (t + 4 > last_due) ? t + 4 : last_due;
         last_due = st + 23;
         filt(scale(c0), 0, f0);
         filt(scale(c1), 1, f1);
         e.x   = f0 ^ 128;
         e.y   = f1 ^ 128;
         e.due = last_due;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      idle(2);
      n_vec++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_%s: pending=%0d busy=%b, required pending=0 busy=0",
                  tag, sb.size(), busy);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && valid) begin
         n_valid++;
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_valid: cyc=%0d x=%02h y=%02h, required no valid",
                     cyc, ux, uy);
         end else begin
            mon_e = sb.pop_front();
            if (ux != mon_e.x || uy != mon_e.y || cyc != mon_e.due) begin
               n_bad++;
               $display("FAIL result: x=%02h y=%02h cyc=%0d, required x=%02h y=%02h cyc=%0d",
                        ux, uy, cyc, mon_e.x[7:0], mon_e.y[7:0], mon_e.due);
            end else begin
               $display("txn %0d: x=%02h y=%02h at cyc %0d", n_valid, ux, uy, cyc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int v0, v1, quiet_start;
      model_reset();

      // Reset state
      idle(3);
      n_vec++;
      if (ux !== 8'h00 || uy !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: x=%02h y=%02h valid=%b busy=%b, required 00 00 0 0",
                  ux, uy, valid, busy);
      end
      reset = 1'b0;
      idle(3);

      // Window endpoints, plus busy during processing
      send(300, 1500, 1);
      idle(10);
      n_vec++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_active: busy=%b, required 1", busy);
      end
      drain("endpoints");

      // Clamping on both sides
      send(100, 4000, 1);
      idle(30);
      send(100, 100, 1);
      idle(30);
      // Mid-scale and just-below-top values
      send(900, 1499, 1);
      idle(30);
      send(1499, 900, 1);
      drain("directed");

      // Three toggles 5 cycles apart: first and last survive
      send(1000, 400, 1);
      idle(4);
      send(2000, 2000, 0);
      idle(4);
      send(350, 1200, 1);
      drain("overwrite");

      // Randomised samples, spacing 24..35 cycles
      for (int i = 0; i < 20; i++) begin
         v0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(250, 1550);
         v1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(250, 1550);
         send(v0, v1, 1);
         idle($urandom_range(23, 34));
      end
      drain("random");

      // Mid-stream reset: leave the toggle line low so release sees no change
      if (adc_sync) begin
         send(700, 700, 1);
         drain("level");
      end
      send(500, 600, 0);
      idle(5);
      send(700, 800, 0);
      idle(8);
      reset = 1'b1;
      sb.delete();
      model_reset();
      idle(2);
      n_vec++;
      if (ux !== 8'h00 || uy !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midstream_reset: x=%02h y=%02h valid=%b busy=%b, required 00 00 0 0",
                  ux, uy, valid, busy);
      end
      reset = 1'b0;
      quiet_start = n_valid;
      idle(30);
      n_vec++;
      if (n_valid != quiet_start || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL quiet_after_reset: valids=%0d busy=%b, required 0 0",
                  n_valid - quiet_start, busy);
      end

      // Repeated full-scale samples from reset (ramps through the average)
      for (int i = 0; i < 5; i++) begin
         send(1500, 1500, 1);
         idle(30);
      end
      drain("fullscale");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/paddle_adc_cond.md
# paddle_adc_cond

Conditions raw LTC2308 ADC conversions into signed 8-bit paddle positions for the console core. It sits between the `ltc2308` ADC interface (clocked on `CLK_50M`) and the paddle mapping logic (clocked on `clk_sys`). It performs four steps:
- synchronises the ADC's new-sample toggle across clocks;
- clamps each channel to a calibrated window;
- rescales with a sequential divider (no combinational divide);
- optionally smooths with a moving average.

## Interface
Parameters:
- `ADC_MIN`, 300: lower clamp bound, raw 12-bit counts.
- `ADC_MAX`, 1500: upper clamp bound; `ADC_MAX-ADC_MIN` must be 1..1200.
- `AVG_LOG2`, 2: log2 of averaging depth (1..4); used only with `PADDLE_AVG_EN`.

Ports:
- `clk_sys  in  1`: system clock. One clock; all outputs are in this domain.
- `reset  in  1`: reset, asynchronous and active-high.
- `adc_sync  in  1`: ADC new-sample toggle from the `CLK_50M` domain. Any level change means a new sample.
- `adc_dout  in  24`: ADC data, {ch1[23:12], ch0[11:0]}. Stable between toggles.
- `paddle_x  out  8`: signed position derived from ch0.
- `paddle_y  out  8`: signed position derived from ch1.
- `valid  out  1`: one-cycle pulse when `paddle_x`/`paddle_y` update.
- `busy  out  1`: high while a sample is being processed.

## Operation
Input capture:
- `adc_sync` passes through a 2-flop synchroniser, then a third flop for edge detection.
- A detected change captures `adc_dout` into a one-deep pending register.
- If pending is already full, the new capture overwrites it (latest wins).

FSM states:
- IDLE → CLAMP when pending is full; pending moves to the work register and `busy`=1.
- CLAMP (1 cycle): c = min(max(raw, ADC_MIN), ADC_MAX) for the current channel. Both bounds apply to both channels.
- MUL (1 cycle): n = (c-ADC_MIN)*255, formed as (d<<8)-d with d = c-ADC_MIN. n is 19 bits unsigned.
- DIV (8 cycles): restoring division q = n / (ADC_MAX-ADC_MIN), truncating toward zero, 8-bit quotient (q ≤ 255 guaranteed).
- FILT (1 cycle): produce the filtered value f (see Configuration).
- After FILT: go to CLAMP for ch1 if ch0 was just done, otherwise DONE.
- DONE (1 cycle): `paddle_x`=f0^8'h80, `paddle_y`=f1^8'h80 (offset-binary to signed), `valid`=1. Then IDLE, or straight to CLAMP if pending is full.

Output behaviour:
- Outputs hold between `valid` pulses.
- `busy` deasserts in the cycle after DONE unless a pending sample starts immediately.

## Timing
- Reset values:
  - `paddle_x`=`paddle_y`=8'h00;
  - `valid`=0, `busy`=0;
  - pending empty, FSM in IDLE;
  - synchroniser flops 0;
  - filter history every entry 128, accumulator 128<<AVG_LOG2.
- Latency: `valid` pulses 26 `clk_sys` cycles after the first synchroniser flop captures the toggle. Breakdown: 2 sync + 1 detect + 2×11 per channel + 1 DONE.
- Per-sample cost: 23 cycles from CLAMP to DONE. Toggle spacing ≥ 24 cycles loses no samples.
- A toggle during processing fills pending. It is processed immediately after DONE with no idle cycle.
- Reset mid-operation: everything clears asynchronously and the pending sample is discarded.

## Configuration
- `PADDLE_AVG_EN` defined:
  - per-channel circular history of 2^AVG_LOG2 quotients plus a running-sum accumulator;
  - FILT does acc += q − oldest, replaces the oldest entry with q, and sets f = acc >> AVG_LOG2 (floor);
  - the write pointer wraps modulo depth.
- Not defined: f = q, no history storage. Latency is unchanged.

## Structure
- Package `paddle_adc_pkg`:
  - FSM state enum;
  - default `ADC_MIN`/`ADC_MAX` constants;
  - scale constant 255;
  - `paddle_t` (logic signed [7:0]).
- Sub-module `paddle_div8`: an 8-iteration restoring divider with start/done, 19-bit dividend, 11-bit divisor. The FSM holds in DIV until done.

## Test plan
1. Assert `reset` mid-stream → all outputs 0, `busy`=0; no `valid` for the next 30 cycles without a toggle.
2. AVG off: ch0=300, ch1=1500, toggle → after 26 cycles `valid` pulses once; `paddle_x`=8'h80, `paddle_y`=8'h7F.
3. AVG off, clamping: ch0=100, ch1=4000 → 8'h80/8'h7F; then ch1=100 → `paddle_y`=8'h80.
4. AVG off: ch0=900 → q=127 → `paddle_x`=8'hFF. ch0=1499 → q=254 → 8'h7E.
5. Three toggles spaced 5 cycles apart, carrying values A, B, C → exactly two `valid` pulses, for A then C. The second pulse comes 23 cycles after the first.
6. AVG on, AVG_LOG2=2, from reset, repeated ch0=1500 samples → `paddle_x` sequence 31, 63, 95, 127, then holds 127.
